// File: rtl/stage_modulator_matrix_pkg.sv
// stage_modulator_matrix_pkg: width derivation, voice/operator id helpers, algorithm fields and FSM states
package stage_modulator_matrix_pkg;
  localparam int ACC_GUARD = 4;
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;
  typedef logic [0:0] fsmState_t;
  function automatic int opWidth(input int numOperators);
    return $clog2(numOperators);
  endfunction
  function automatic int voWidth(input int numVoices, input int numOperators);
    return $clog2(numVoices) + $clog2(numOperators);
  endfunction
  function automatic int algWidth(input int numOperators);
    return numOperators + 4;
  endfunction
  function automatic int accWidth(input int phaseWidth);
    return phaseWidth + ACC_GUARD;
  endfunction
  function automatic int getVoiceID(input int vo, input int numOperators);
    return vo >> $clog2(numOperators);
  endfunction
  function automatic int getOperatorID(input int vo, input int numOperators);
    return vo & ((1 << $clog2(numOperators)) - 1);
  endfunction
  function automatic int makeVoiceOperatorID(input int voice, input int op, input int numOperators);
    return (voice << $clog2(numOperators)) | op;
  endfunction
  function automatic int getMask(input int word, input int numOperators);
    return word & ((1 << numOperators) - 1);
  endfunction
  function automatic int getFeedback(input int word, input int numOperators);
    return (word >> numOperators) & 7;
  endfunction
  function automatic int getCarrier(input int word, input int numOperators);
    return (word >> (numOperators + 3)) & 1;
  endfunction
endpackage

// File: rtl/stage_modulator_matrix_if.sv
// stage_modulator_matrix_if: slot, config and writeback bus of the modulation matrix stage
interface stage_modulator_matrix_if #(
  parameter int NUM_OPERATORS = 6,
  parameter int NUM_VOICES = 32,
  parameter int PHASE_WIDTH = 16,
  parameter int OUTPUT_WIDTH = 16,
  localparam int VO_W = stage_modulator_matrix_pkg::voWidth(NUM_VOICES, NUM_OPERATORS),
  localparam int ALG_W = stage_modulator_matrix_pkg::algWidth(NUM_OPERATORS)
);
  logic i_Valid;
  logic [PHASE_WIDTH-1:0] i_Phase;
  logic i_NoteOn;
  logic [VO_W-1:0] i_VoiceOperator;
  logic o_Ready;
  logic o_Valid;
  logic [PHASE_WIDTH-1:0] o_Phase;
  logic o_NoteOn;
  logic [VO_W-1:0] o_VoiceOperator;
  logic [ALG_W-1:0] o_AlgorithmWord;
  logic i_OperatorWritebackEnable;
  logic [VO_W-1:0] i_OperatorWritebackID;
  logic [OUTPUT_WIDTH-1:0] i_OperatorWritebackValue;
  logic i_AlgorithmWriteEnable;
  logic [VO_W-1:0] i_ConfigWriteAddr;
  logic [ALG_W-1:0] i_ConfigWriteData;
  modport master (
    output i_Valid, i_Phase, i_NoteOn, i_VoiceOperator, i_OperatorWritebackEnable, i_OperatorWritebackID,
    output i_OperatorWritebackValue, i_AlgorithmWriteEnable, i_ConfigWriteAddr, i_ConfigWriteData,
    input o_Ready, o_Valid, o_Phase, o_NoteOn, o_VoiceOperator, o_AlgorithmWord
  );
  modport slave (
    input i_Valid, i_Phase, i_NoteOn, i_VoiceOperator, i_OperatorWritebackEnable, i_OperatorWritebackID,
    input i_OperatorWritebackValue, i_AlgorithmWriteEnable, i_ConfigWriteAddr, i_ConfigWriteData,
    output o_Ready, o_Valid, o_Phase, o_NoteOn, o_VoiceOperator, o_AlgorithmWord
  );
endinterface

// File: rtl/stage_modulator_matrix_term_stage.sv
// modulator_term_stage: one operator term (RAM copy, mask/feedback select, add); MODULATOR_FEEDBACK_EN scales the own-op term
module modulator_term_stage
  import stage_modulator_matrix_pkg::*;
#(
  parameter int NUM_OPERATORS = 6,
  parameter int NUM_VOICES = 32,
  parameter int PHASE_WIDTH = 16,
  parameter int OUTPUT_WIDTH = 16,
  parameter int STAGE = 0,
  localparam int VO_W = voWidth(NUM_VOICES, NUM_OPERATORS),
  localparam int ALG_W = algWidth(NUM_OPERATORS),
  localparam int ACC_W = accWidth(PHASE_WIDTH)
) (
  input logic i_Clock,
  input logic i_Reset,
  input logic i_WriteEnable,
  input logic [VO_W-1:0] i_WriteAddr,
  input logic [OUTPUT_WIDTH-1:0] i_WriteData,
  input logic i_Valid,
  input logic [ACC_W-1:0] i_Acc,
  input logic [ALG_W-1:0] i_Word,
  input logic [VO_W-1:0] i_VoiceOperator,
  input logic i_NoteOn,
  output logic o_Valid,
  output logic [ACC_W-1:0] o_Acc,
  output logic [ALG_W-1:0] o_Word,
  output logic [VO_W-1:0] o_VoiceOperator,
  output logic o_NoteOn
);
  localparam int DEPTH = 1 << VO_W;
  logic [OUTPUT_WIDTH-1:0] opRam [DEPTH];
  logic [VO_W-1:0] readAddr;
  logic signed [ACC_W-1:0] value;
  logic signed [ACC_W-1:0] term;
  // asynchronous read sees the old entry when the same address is written this cycle
  assign readAddr = VO_W'(makeVoiceOperatorID(getVoiceID(int'(i_VoiceOperator), NUM_OPERATORS), STAGE, NUM_OPERATORS));
  assign value = ACC_W'($signed(opRam[readAddr]));
`ifdef MODULATOR_FEEDBACK_EN
  logic [2:0] feedback;
  logic signed [ACC_W-1:0] scaled;
  assign feedback = 3'(getFeedback(int'(i_Word), NUM_OPERATORS));
  assign scaled = value >>> (4'd8 - {1'b0, feedback});
  assign term = getOperatorID(int'(i_VoiceOperator), NUM_OPERATORS) == STAGE ? (feedback == 3'd0 ? '0 : scaled)
              : i_Word[STAGE] ? value : '0;
`else
  assign term = i_Word[STAGE] ? value : '0;
`endif
  always_ff @(posedge i_Clock)
    if (i_WriteEnable) opRam[i_WriteAddr] <= i_WriteData;
  always_ff @(posedge i_Clock)
    if (i_Reset) begin
      {o_Valid, o_Acc, o_Word, o_VoiceOperator, o_NoteOn} <= '0;
    end else begin
      o_Valid <= i_Valid;
      o_Acc <= i_Acc + term;
      o_Word <= i_Word;
      o_VoiceOperator <= i_VoiceOperator;
      o_NoteOn <= i_NoteOn;
    end
endmodule

// File: rtl/stage_modulator_matrix.sv
// stage_modulator_matrix: post-reset RAM clear then an N+1 stage phase modulation pipeline; MODULATOR_FEEDBACK_EN enables self-feedback
module stage_modulator_matrix
  import stage_modulator_matrix_pkg::*;
#(
  parameter int NUM_OPERATORS = 6,
  parameter int NUM_VOICES = 32,
  parameter int PHASE_WIDTH = 16,
  parameter int OUTPUT_WIDTH = 16,
  localparam int VO_W = voWidth(NUM_VOICES, NUM_OPERATORS),
  localparam int ALG_W = algWidth(NUM_OPERATORS),
  localparam int ACC_W = accWidth(PHASE_WIDTH)
) (
  input logic i_Clock,
  input logic i_Reset,
  stage_modulator_matrix_if.slave bus
);
  localparam int DEPTH = 1 << VO_W;
  fsmState_t state;
  logic [VO_W-1:0] clearCount;
  logic clearing;
  logic ready;
  logic [ALG_W-1:0] algRam [DEPTH];
  logic s0Valid;
  logic s0NoteOn;
  logic [ACC_W-1:0] s0Acc;
  logic [ALG_W-1:0] s0Word;
  logic [VO_W-1:0] s0Vo;
  logic validPipe [NUM_OPERATORS+1];
  logic noteOnPipe [NUM_OPERATORS+1];
  logic [ACC_W-1:0] accPipe [NUM_OPERATORS+1];
  logic [ALG_W-1:0] wordPipe [NUM_OPERATORS+1];
  logic [VO_W-1:0] voPipe [NUM_OPERATORS+1];
  logic wrEn;
  logic [VO_W-1:0] wrAddr;
  logic [OUTPUT_WIDTH-1:0] wrData;
  logic unusedAccBits;
  assign clearing = state == ST_CLEAR;
  assign ready = state == ST_RUN;
  // the clear sweep owns every RAM write port until it finishes
  assign wrEn = clearing || bus.i_OperatorWritebackEnable;
  assign wrAddr = clearing ? clearCount : bus.i_OperatorWritebackID;
  assign wrData = clearing ? '0 : bus.i_OperatorWritebackValue;
  always_ff @(posedge i_Clock)
    if (i_Reset) begin
      state <= ST_CLEAR;
      clearCount <= '0;
    end else if (clearing) begin
      clearCount <= clearCount + 1'b1;
      state <= &clearCount ? ST_RUN : ST_CLEAR;
    end
  always_ff @(posedge i_Clock)
    if (clearing) algRam[clearCount] <= '0;
    else if (bus.i_AlgorithmWriteEnable) algRam[bus.i_ConfigWriteAddr] <= bus.i_ConfigWriteData;
  always_ff @(posedge i_Clock)
    if (i_Reset) begin
      {s0Valid, s0NoteOn, s0Acc, s0Word, s0Vo} <= '0;
    end else begin
      s0Valid <= bus.i_Valid && ready;
      s0Acc <= ACC_W'(bus.i_Phase);
      s0Word <= algRam[bus.i_VoiceOperator];
      s0Vo <= bus.i_VoiceOperator;
      s0NoteOn <= bus.i_NoteOn;
    end
  assign validPipe[0] = s0Valid;
  assign noteOnPipe[0] = s0NoteOn;
  assign accPipe[0] = s0Acc;
  assign wordPipe[0] = s0Word;
  assign voPipe[0] = s0Vo;
  for (genvar k = 0; k < NUM_OPERATORS; k++) begin : g_term
    modulator_term_stage #(
      .NUM_OPERATORS(NUM_OPERATORS),
      .NUM_VOICES(NUM_VOICES),
      .PHASE_WIDTH(PHASE_WIDTH),
      .OUTPUT_WIDTH(OUTPUT_WIDTH),
      .STAGE(k)
    ) u_term (
      .i_Clock(i_Clock),
      .i_Reset(i_Reset),
      .i_WriteEnable(wrEn),
      .i_WriteAddr(wrAddr),
      .i_WriteData(wrData),
      .i_Valid(validPipe[k]),
      .i_Acc(accPipe[k]),
      .i_Word(wordPipe[k]),
      .i_VoiceOperator(voPipe[k]),
      .i_NoteOn(noteOnPipe[k]),
      .o_Valid(validPipe[k+1]),
      .o_Acc(accPipe[k+1]),
      .o_Word(wordPipe[k+1]),
      .o_VoiceOperator(voPipe[k+1]),
      .o_NoteOn(noteOnPipe[k+1])
    );
  end
  assign bus.o_Ready = ready;
  assign bus.o_Valid = validPipe[NUM_OPERATORS];
  assign bus.o_Phase = accPipe[NUM_OPERATORS][PHASE_WIDTH-1:0];
  assign bus.o_NoteOn = noteOnPipe[NUM_OPERATORS];
  assign bus.o_VoiceOperator = voPipe[NUM_OPERATORS];
  assign bus.o_AlgorithmWord = wordPipe[NUM_OPERATORS];
  assign unusedAccBits = ^accPipe[NUM_OPERATORS][ACC_W-1:PHASE_WIDTH];
endmodule

// File: doc/stage_modulator_matrix.md
Name: stage_modulator_matrix

Overview:
- Parametrised successor to the fixed 6-op phase modulator stage. Adds the operator-output modulation terms selected by a per-voice-operator algorithm word to a raw phase.
- Generalised in operator count, voice count and phase width. Adds a valid/ready front end, a post-reset memory clear, and an optional scaled self-feedback path.
- Sits between the phase accumulator stage and the waveform/envelope stages; operator writeback arrives from the pipeline tail.

Parameters:
- NUM_OPERATORS, 6, operators per voice (2..8).
- NUM_VOICES, 32, voices (power of 2).
- PHASE_WIDTH, 16, raw and modulated phase width.
- OUTPUT_WIDTH, 16, signed operator writeback width.

Ports:
- i_Clock  in  1  clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Valid  in  1  input slot valid; sampled only while o_Ready=1.
- i_Phase  in  PHASE_WIDTH  raw unsigned phase.
- i_NoteOn  in  1  passed through.
- i_VoiceOperator  in  VO_W  {voice, op}; OP_W=$clog2(NUM_OPERATORS), VO_W=$clog2(NUM_VOICES)+OP_W.
- o_Ready  out  1  block accepts input and config.
- o_Valid  out  1  output slot valid.
- o_Phase  out  PHASE_WIDTH  modulated phase, modulo 2^PHASE_WIDTH.
- o_NoteOn  out  1  delayed i_NoteOn.
- o_VoiceOperator  out  VO_W  delayed i_VoiceOperator.
- o_AlgorithmWord  out  ALG_W  algorithm word used for this slot; ALG_W=NUM_OPERATORS+4.
- i_OperatorWritebackEnable  in  1  write operator output.
- i_OperatorWritebackID  in  VO_W  writeback address.
- i_OperatorWritebackValue  in  OUTPUT_WIDTH  signed operator output.
- i_AlgorithmWriteEnable  in  1  config write strobe.
- i_ConfigWriteAddr  in  VO_W  algorithm entry address.
- i_ConfigWriteData  in  ALG_W  [N-1:0] modulation mask; [N+2:N] feedback level FB; [N+3] carrier flag (passthrough only).

Behaviour:
- Memories:
  - Algorithm RAM and operator-output RAM, each with depth NUM_VOICES*2^OP_W.
  - Operator-output RAM is replicated NUM_OPERATORS times, one read port per stage.
  - Reads are read-before-write: a writeback in cycle t is visible to reads in cycle t+1 and later.
- FSM: CLEAR and RUN.
  - i_Reset forces CLEAR with the clear counter at 0, o_Ready=0, o_Valid=0, o_Phase=0, o_NoteOn=0, o_VoiceOperator=0, o_AlgorithmWord=0, and all pipeline valids=0.
  - In CLEAR: one entry of both RAMs is zeroed per cycle; i_Valid, config writes and writebacks are ignored.
  - After the last entry (256 cycles after reset release at defaults), go to RUN; o_Ready=1.
  - Reset asserted mid-CLEAR or mid-RUN restarts the clear from 0 and drops in-flight slots.
- Pipeline: NUM_OPERATORS+1 stages; latency 7 at defaults. One slot per cycle, no stalls.
  - Stage 0 registers the phase zero-extended into ACC_W=PHASE_WIDTH+4 bits, plus the algorithm word, VO, NoteOn and valid.
  - Stage k (1..N) adds sign-extended operator k-1 output of the same voice if mask[k-1]=1; otherwise passes through.
  - o_Phase = accumulator[PHASE_WIDTH-1:0]. Wrap is intended.
- Simultaneous config write and read of the same address: the read returns the old word.
- A config write and a writeback in the same cycle are independent.

Optional Feature:
- Macro: MODULATOR_FEEDBACK_EN.
- Defined: for the stage whose index equals the slot's own op, mask bit behaviour is replaced.
  - FB=0: self term is 0.
  - FB=1..7: self term = (value >>> (8-FB)), arithmetic shift.
- Undefined: the FB field is ignored but still passed out on o_AlgorithmWord; the own-op mask bit acts as a normal mask bit.

Decomposition:
- Shared synth package:
  - VO_W/OP_W/ALG_W derivation functions, getVoiceID/makeVoiceOperatorID.
  - Algorithm field-extract functions, ACC_W constant.
  - FSM state enum.
- Sub-module modulator_term_stage: one pipeline stage with a RAM read port, mask test and add; instantiated NUM_OPERATORS times via generate.

Test Plan:
- Reset release -> o_Ready=0 for exactly 256 cycles, then 1; o_Valid=0 throughout; all RAM reads return 0.
- Mask=0, i_Phase=0x1234, VO=5 -> o_Valid and o_Phase=0x1234 exactly 7 cycles later; NoteOn, VO and word delayed identically.
- Voice 2: write op1=+0x0100 and op3=-0x0010, mask=0b001010, i_Phase=0x1000 -> o_Phase=0x10F0.
- i_Phase=0xFFF0, op0=+0x0020, mask bit0 -> o_Phase=0x0010 (wrap).
- MODULATOR_FEEDBACK_EN defined, VO {v0,op2}, op2=0x0400, mask bit2, FB=6 -> term 0x0100; FB=0 -> term 0.
- Reset pulsed with 3 slots in flight -> no o_Valid until a new post-clear input.
